// File: rtl/radix4_divider.sv
// Unsigned 2N/N radix-4 restoring divider, two quotient bits retired per cycle.
// Latency: result valid K cycles after accept (1 cycle for divide-by-zero / overflow).
// Backpressure: single result slot held in DONE until out_ready; in_ready only while IDLE.
module radix4_divider #(
    parameter int N = 8,
    localparam int K = N / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   x,
    output logic [N-1:0]   r,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = $clog2(K + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N+1:0]  rem;
    logic [N-1:0]  low;
    logic [N-1:0]  quo;
    logic [N-1:0]  div;
    logic [CW-1:0] cnt;
    logic          exc;

    logic [N+1:0]  t;
    logic [N+1:0]  y1;
    logic [N+1:0]  y2;
    logic [N+1:0]  y3;
    logic [N+1:0]  rem_nxt;
    logic [1:0]    d;
    logic [N-1:0]  q_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // rem is always below the divisor, so shifting the full register cannot lose bits.
    always_comb begin
        t       = (rem << 2) | {{N{1'b0}}, low[N-1:N-2]};
        y1      = {2'b00, div};
        y2      = {1'b0, div, 1'b0};
        y3      = y1 + y2;
        d       = 2'd0;
        rem_nxt = t;
        if (t >= y3) begin
            d       = 2'd3;
            rem_nxt = t - y3;
        end else if (t >= y2) begin
            d       = 2'd2;
            rem_nxt = t - y2;
        end else if (t >= y1) begin
            d       = 2'd1;
            rem_nxt = t - y1;
        end
        q_nxt = (quo << 2) | {{(N-2){1'b0}}, d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            low   <= '0;
            quo   <= '0;
            div   <= '0;
            cnt   <= '0;
            exc   <= 1'b0;
            x     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div <= y;
                        if (y == '0) begin
                            dz    <= 1'b1;
                            ovf   <= 1'b0;
                            x     <= '1;
                            r     <= p[N-1:0];
                            exc   <= 1'b1;
                            state <= ITER;
                        end else if (p[2*N-1:N] >= y) begin
                            dz    <= 1'b0;
                            ovf   <= 1'b1;
                            x     <= '1;
                            r     <= '0;
                            exc   <= 1'b1;
                            state <= ITER;
                        end else begin
                            rem   <= {2'b00, p[2*N-1:N]};
                            low   <= p[N-1:0];
                            quo   <= '0;
                            cnt   <= CW'(K);
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    // Exceptions spend one pass here so their result appears one cycle after accept.
                    if (exc) begin
                        exc   <= 1'b0;
                        state <= DONE;
                    end else begin
                        rem <= rem_nxt;
                        low <= low << 2;
                        quo <= q_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            x     <= q_nxt;
                            r     <= rem_nxt[N-1:0];
                            dz    <= 1'b0;
                            ovf   <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_divider.sv
// Self-checking bench for radix4_divider: directed vector table, hand-written
// backpressure/reset sequences and a randomised sweep against an arithmetic model.
module tb_radix4_divider;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] p;
    logic [N-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   r;
    logic           dz;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    radix4_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .r         (r),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0] p;
        logic [N-1:0]   y;
        logic [N-1:0]   x;
        logic [N-1:0]   r;
        logic           dz;
        logic           ovf;
        int             lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the documented flag rules.
    function automatic logic [2*N+1:0] model(input logic [2*N-1:0] pp, input logic [N-1:0] yy,
                                               output int lat);
        int unsigned q;
        if (yy == 0) begin
            lat = 1;
            return {1'b1, 1'b0, {N{1'b1}}, pp[N-1:0]};
        end
        q = 32'(pp) / 32'(yy);
        if (q >= (1 << N)) begin
            lat = 1;
            return {1'b0, 1'b1, {N{1'b1}}, {N{1'b0}}};
        end
        lat = N / 2;
        return {1'b0, 1'b0, N'(q), N'(32'(pp) % 32'(yy))};
    endfunction

    // Issue one operand pair, wait for the result, then hand it off.
    // Called and returns at a negedge; lat counts posedges after the accept edge.
    task automatic do_op(input logic [2*N-1:0] pp, input logic [N-1:0] yy,
                         output logic [2*N+1:0] res, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        p = pp;
        y = yy;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        p = 16'($urandom);
        y = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        res = {dz, ovf, x, r};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        logic [2*N+1:0] res;
        logic [2*N+1:0] exp_res;
        logic [2*N-1:0] rp;
        logic [N-1:0]   ry;
        int lat;
        int exp_lat;
        int guard;
        int sel;
        logic bad;

        vecs[0] = '{16'd1000,  8'd7,   8'd142,  8'd6,   1'b0, 1'b0, 4};
        vecs[1] = '{16'hFEFF,  8'hFF,  8'hFF,   8'hFE,  1'b0, 1'b0, 4};
        vecs[2] = '{16'h0000,  8'h01,  8'h00,   8'h00,  1'b0, 1'b0, 4};
        vecs[3] = '{16'h1234,  8'h00,  8'hFF,   8'h34,  1'b1, 1'b0, 1};
        vecs[4] = '{16'hFFFE,  8'hFF,  8'hFF,   8'h00,  1'b0, 1'b1, 1};
        vecs[5] = '{16'd50,    8'd9,   8'd5,    8'd5,   1'b0, 1'b0, 4};
        vecs[6] = '{16'h00FF,  8'h01,  8'hFF,   8'h00,  1'b0, 1'b0, 4};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        p = '0;
        y = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, x, r, dz, ovf}, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].p, vecs[i].y, res, lat);
            check($sformatf("vec%0d_result", i), 32'(res),
                  32'({vecs[i].dz, vecs[i].ovf, vecs[i].x, vecs[i].r}));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_idle_after", i), {in_ready, out_valid}, 2'b10);
        end

        // Backpressure: result held through 3 stalled cycles; stray in_valid ignored.
        p = 16'd255;
        y = 8'd16;
        in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        bad = 1'b0;
        while (!out_valid && lat < 30) begin
            in_valid = lat[0];
            p = 16'h0101;
            y = 8'd0;
            if (in_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 4);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            check($sformatf("bp_hold%0d", c), {out_valid, in_ready, dz, ovf, x, r},
                  {1'b1, 1'b0, 1'b0, 1'b0, 8'd15, 8'd15});
            @(negedge clk);
        end
        check("bp_in_ready_low_in_iter", 32'(bad), 32'd0);
        in_valid = 1'b0;
        check("bp_still_held", {out_valid, x, r}, {1'b1, 8'd15, 8'd15});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_after_handshake", {in_ready, out_valid}, 2'b10);

        // Reset during iteration discards the in-flight result.
        p = 16'd1000;
        y = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_state", {out_valid, in_ready, x, r}, {1'b0, 1'b1, 8'h00, 8'h00});
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) bad = 1'b1;
            @(negedge clk);
        end
        check("midreset_no_stale_result", 32'(bad), 32'd0);
        do_op(16'd50, 8'd9, res, lat);
        check("after_reset_op", 32'(res), 32'({1'b0, 1'b0, 8'd5, 8'd5}));

        // Randomised sweep with edge-value bias.
        for (int i = 0; i < 6000; i++) begin
            sel = int'($urandom_range(0, 9));
            ry = 8'($urandom);
            rp = 16'($urandom);
            case (sel)
                0: ry = 8'd0;
                1: ry = 8'd1;
                2: ry = 8'hFF;
                3: rp = 16'd0;
                4, 5, 6: begin
                    if (ry == 0) ry = 8'd1;
                    rp = 16'($urandom_range(0, 32'(ry) * 256 - 1));
                end
                default: ;
            endcase
            exp_res = model(rp, ry, exp_lat);
            do_op(rp, ry, res, lat);
            if (res !== exp_res || lat != exp_lat) begin
                $display("  operands p=0x%0h y=0x%0h latency %0d (want %0d)", rp, ry, lat, exp_lat);
            end
            check("rand_result", 32'(res), 32'(exp_res));
            check("rand_latency", lat, exp_lat);
        end

        guard = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
